result_display: RTL and testbench

- Downstream consumer of the controller's 16-bit result output (outResult). Drives a 4-digit multiplexed common-anode 7-segment display.
- Shows the latched result in hex or in unsigned decimal. Decimal uses a sequential double-dabble binary-to-BCD converter.
- Display contents update atomically, so a digit pattern never tears mid-refresh.

---
 rtl/result_display_if.sv | 40 ++++
 rtl/result_display.sv | 245 ++++++++++++++++++++++++
 tb/tb_result_display.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/result_display_if.sv
// ---------------------------------------------------------------------------
// result_display_if
// Bundles the signals between the controller side (result word, display mode)
// and the 4-digit multiplexed 7-segment display driver.
//   value : 16-bit result word from the controller (outResult)
//   mode  : 0 = hexadecimal, 1 = unsigned decimal
//   seg   : segments {g,f,e,d,c,b,a}, seg[0] = a
//   dp    : decimal point of the currently enabled digit
//   an    : digit enables, an[0] = rightmost digit
//   busy  : high while a decimal conversion is in progress
// Modports:
//   master : producer of value/mode, consumer of the display signals
//   slave  : the display driver itself
// ---------------------------------------------------------------------------
interface result_display_if;
   logic [15:0] value;
   logic        mode;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;

   modport master (
      output value,
      output mode,
      input  seg,
      input  dp,
      input  an,
      input  busy
   );

   modport slave (
      input  value,
      input  mode,
      output seg,
      output dp,
      output an,
      output busy
   );
endinterface

// File: rtl/result_display.sv
// ---------------------------------------------------------------------------
// result_display
// Shows the controller's 16-bit result on a 4-digit multiplexed common-anode
// 7-segment display, either as hex or as unsigned decimal. Decimal uses a
// sequential double-dabble converter (one add-3/shift step per cycle). The
// shown digits are a single register written in one cycle, so the refresh
// never displays a half-updated number.
//
// Ports:
//   clock : system clock (same clock as the controller)
//   reset : asynchronous active-low reset, synchronous release
//   bus   : result_display_if.slave (value, mode in; seg, dp, an, busy out)
//
// Parameters:
//   REFRESH_DIV    : cycles each digit stays lit before advancing (>= 2)
//   SEG_ACTIVE_LOW : 1 = segment (and dp) lit when its bit is 0
//   AN_ACTIVE_LOW  : 1 = digit enabled when its an bit is 0
//
// Optional feature macro: RESULT_DISPLAY_BLANK_ZERO_EN
//   defined   : leading zeros are blanked (digit 0 is always shown)
//   undefined : all four digits are always shown
// ---------------------------------------------------------------------------
module result_display #(
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   result_display_if.slave bus
);

   localparam int unsigned      CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_HEX      = 2'd1;
   localparam logic [1:0] ST_DD_SHIFT = 2'd2;
   localparam logic [1:0] ST_DD_DONE  = 2'd3;

   localparam logic [4:0] DD_STEPS = 5'd16;

   // XOR masks turn an active-high "lit/enabled" pattern into pin polarity.
   localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};
   localparam logic [3:0] AN_MASK  = {4{AN_ACTIVE_LOW}};
   localparam logic       DP_MASK  = SEG_ACTIVE_LOW;

   // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'h0:    p = 7'h3F;
         4'h1:    p = 7'h06;
         4'h2:    p = 7'h5B;
         4'h3:    p = 7'h4F;
         4'h4:    p = 7'h66;
         4'h5:    p = 7'h6D;
         4'h6:    p = 7'h7D;
         4'h7:    p = 7'h07;
         4'h8:    p = 7'h7F;
         4'h9:    p = 7'h6F;
         4'hA:    p = 7'h77;
         4'hB:    p = 7'h7C;
         4'hC:    p = 7'h39;
         4'hD:    p = 7'h5E;
         4'hE:    p = 7'h79;
         4'hF:    p = 7'h71;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   // One double-dabble step: BCD nibbles live in [35:16], binary in [15:0].
   // Every BCD nibble >= 5 gets +3 so the following shift carries correctly.
   function automatic logic [35:0] dd_step(input logic [35:0] s);
      logic [35:0] t;
      logic [3:0]  nib;
      t = s;
      for (int k = 0; k < 5; k++) begin
         nib = t[16 + 4*k +: 4];
         t[16 + 4*k +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
      return {t[34:0], 1'b0};
   endfunction

   logic [1:0]       state_q,    state_d;
   logic [15:0]      cap_val_q,  cap_val_d;
   logic             cap_mode_q, cap_mode_d;
   logic [35:0]      shift_q,    shift_d;
   logic [4:0]       iter_q,     iter_d;
   logic             busy_q,     busy_d;
   logic [15:0]      shown_q,    shown_d;
   logic             ovf_q,      ovf_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [1:0]       idx_q,      idx_d;
   logic [6:0]       seg_q,      seg_d;
   logic [3:0]       an_q,       an_d;
   logic             dp_q,       dp_d;

   logic [3:0]       digit_s;
   logic [3:0]       an_raw_s;
   logic [3:0]       lead_zero_s;
   logic             blank_s;
   logic [6:0]       seg_raw_s;

   // Capture / conversion FSM next-state logic.
   always_comb begin
      state_d    = state_q;
      cap_val_d  = cap_val_q;
      cap_mode_d = cap_mode_q;
      shift_d    = shift_q;
      iter_d     = iter_q;
      busy_d     = busy_q;
      shown_d    = shown_q;
      ovf_d      = ovf_q;
      case (state_q)
         ST_IDLE: begin
            // Changes made while busy are picked up here on the way back.
            if ((bus.value != cap_val_q) || (bus.mode != cap_mode_q)) begin
               cap_val_d  = bus.value;
               cap_mode_d = bus.mode;
               if (bus.mode) begin
                  state_d = ST_DD_SHIFT;
                  shift_d = {20'd0, bus.value};
                  iter_d  = 5'd0;
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_HEX;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HEX: begin
            shown_d = cap_val_q;
            ovf_d   = 1'b0;
            state_d = ST_IDLE;
         end
         ST_DD_SHIFT: begin
            if (iter_q == DD_STEPS) begin
               state_d = ST_DD_DONE;
            end else begin
               shift_d = dd_step(shift_q);
               iter_d  = iter_q + 5'd1;
            end
         end
         ST_DD_DONE: begin
            shown_d = shift_q[31:16];
            ovf_d   = (shift_q[35:32] != 4'd0);
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Refresh divider and digit index, free-running regardless of the FSM.
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
         idx_d = idx_q;
      end
   end

`ifdef RESULT_DISPLAY_BLANK_ZERO_EN
   // Leading-zero map: digit k is blank when it and every digit above are 0.
   always_comb begin
      lead_zero_s[3] = (shown_q[15:12] == 4'd0);
      lead_zero_s[2] = lead_zero_s[3] && (shown_q[11:8] == 4'd0);
      lead_zero_s[1] = lead_zero_s[2] && (shown_q[7:4] == 4'd0);
      lead_zero_s[0] = 1'b0;
   end
`else
   // No blanking: every digit is always drawn.
   always_comb begin
      lead_zero_s = 4'b0000;
   end
`endif

   // Select and decode the digit at the current index for the output stage.
   always_comb begin
      case (idx_q)
         2'd0:    begin digit_s = shown_q[3:0];   an_raw_s = 4'b0001; end
         2'd1:    begin digit_s = shown_q[7:4];   an_raw_s = 4'b0010; end
         2'd2:    begin digit_s = shown_q[11:8];  an_raw_s = 4'b0100; end
         2'd3:    begin digit_s = shown_q[15:12]; an_raw_s = 4'b1000; end
         default: begin digit_s = 4'd0;           an_raw_s = 4'b0000; end
      endcase
      blank_s = lead_zero_s[idx_q];
      if (blank_s) begin
         seg_raw_s = 7'h00;
      end else begin
         seg_raw_s = hex7(digit_s);
      end
      seg_d = seg_raw_s ^ SEG_MASK;
      an_d  = an_raw_s ^ AN_MASK;
      dp_d  = ((idx_q == 2'd3) && ovf_q) ^ DP_MASK;
   end

   // State, datapath and registered display outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cap_val_q  <= 16'd0;
         cap_mode_q <= 1'b0;
         shift_q    <= 36'd0;
         iter_q     <= 5'd0;
         busy_q     <= 1'b0;
         shown_q    <= 16'd0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         seg_q      <= SEG_MASK;
         an_q       <= AN_MASK;
         dp_q       <= DP_MASK;
      end else begin
         state_q    <= state_d;
         cap_val_q  <= cap_val_d;
         cap_mode_q <= cap_mode_d;
         shift_q    <= shift_d;
         iter_q     <= iter_d;
         busy_q     <= busy_d;
         shown_q    <= shown_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         dp_q       <= dp_d;
      end
   end

   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
   assign bus.dp   = dp_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_result_display.sv
// ---------------------------------------------------------------------------
// tb_result_display
// Scoreboard bench for result_display with REFRESH_DIV = 4 and active-low
// outputs. The stimulus process pushes time-stamped expected observations
// (digit shown at a given cycle, busy level at a given cycle) into a sorted
// queue; the monitor pops and compares them on the falling clock edge.
// Cycle numbering: cyc = rising edges since reset release.
// ---------------------------------------------------------------------------
module tb_result_display;

   typedef struct {
      int         due;
      int         kind;   // 0 = digit, 1 = busy, 2 = full (reset)
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       busy;
   } item_t;

`ifdef RESULT_DISPLAY_BLANK_ZERO_EN
   localparam bit BZ = 1'b1;
`else
   localparam bit BZ = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_chk;
   int   n_err;
   bit   finish_req = 1'b0;
   item_t sb_q[$];
   logic [3:0][6:0] cur_segs;
   logic            cur_ovf;

   result_display_if bus_if ();

   result_display #(
      .REFRESH_DIV   (4),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW (1'b1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if)
   );

   always #5 clock = ~clock;

   always @(posedge clock or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic sb_push(input item_t it);
      int p;
      p = sb_q.size();
      while (p > 0 && sb_q[p-1].due > it.due) p--;
      sb_q.insert(p, it);
   endtask

   // Expected output at cycle d: digit ((d-1)/4)%4 is enabled.
   task automatic push_digit(input int d, input logic [3:0][6:0] segs, input logic ovf);
      item_t it;
      int    idx;
      idx     = ((d - 1) / 4) % 4;
      it.due  = d;
      it.kind = 0;
      it.an   = 4'b1111;
      it.an[idx] = 1'b0;
      it.seg  = segs[idx];
      it.dp   = !(ovf && (idx == 3));
      it.busy = 1'b0;
      sb_push(it);
   endtask

   task automatic push_scan(input int from, input logic [3:0][6:0] segs, input logic ovf);
      for (int d = from; d < from + 16; d++)
         if (((d - 1) % 4) == 0) push_digit(d, segs, ovf);
   endtask

   task automatic push_busy(input int d, input logic b);
      item_t it;
      it.due = d; it.kind = 1; it.an = 4'b0000; it.seg = 7'h00; it.dp = 1'b0; it.busy = b;
      sb_push(it);
   endtask

   task automatic push_inactive();
      item_t it;
      it.due = 0; it.kind = 2; it.an = 4'b1111; it.seg = 7'h7F; it.dp = 1'b1; it.busy = 1'b0;
      sb_push(it);
   endtask

   task automatic run_to(input int c);
      while (cyc < c) begin
         @(posedge clock);
         #2;
      end
   endtask

   // Drive a new value/mode; hex shows up 2 cycles later, decimal 19.
   task automatic apply(input logic [15:0] v, input logic m,
                        input logic [3:0][6:0] segs, input logic ovf);
      int k;
      int lat;
      k   = cyc;
      bus_if.value = v;
      bus_if.mode  = m;
      lat = m ? 19 : 2;
      for (int d = k + 1; d <= k + lat + 1; d++) push_busy(d, m && (d <= k + 18));
      push_digit(k + lat, cur_segs, cur_ovf);
      push_digit(k + lat + 1, segs, ovf);
      push_scan(k + lat + 1, segs, ovf);
      cur_segs = segs;
      cur_ovf  = ovf;
      run_to(k + lat + 17);
   endtask

   // Monitor: compares every due expectation against the DUT outputs.
   initial begin
      item_t it;
      string nm;
      bit    ok;
      n_chk = 0;
      n_err = 0;
      forever begin
         @(negedge clock);
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            it = sb_q.pop_front();
            n_chk++;
            case (it.kind)
               0: begin nm = "digit"; ok = ({bus_if.an, bus_if.seg, bus_if.dp} === {it.an, it.seg, it.dp}); end
               1: begin nm = "busy";  ok = (bus_if.busy === it.busy); end
               default: begin
                  nm = "reset";
                  ok = ({bus_if.an, bus_if.seg, bus_if.dp, bus_if.busy} === {it.an, it.seg, it.dp, it.busy});
               end
            endcase
            if (it.due != cyc) begin
               ok = 1'b0;
               nm = "late";
            end
            if (!ok) begin
               n_err++;
               $display("FAIL %s due=%0d cyc=%0d: got an=%b seg=%h dp=%b busy=%b, expected an=%b seg=%h dp=%b busy=%b",
                        nm, it.due, cyc, bus_if.an, bus_if.seg, bus_if.dp, bus_if.busy,
                        it.an, it.seg, it.dp, it.busy);
            end
         end
         if (finish_req) begin
            n_chk++;
            if (sb_q.size() != 0) begin
               n_err++;
               $display("FAIL sb_drain: got %0d pending expectations, expected 0", sb_q.size());
            end
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $finish;
         end
      end
   end

   // Stimulus.
   initial begin
      logic [3:0][6:0] s100;
      logic [3:0][6:0] s42;
      int k;
      reset        = 1'b0;
      bus_if.value = 16'd0;
      bus_if.mode  = 1'b0;
      cur_segs     = {7'h40, 7'h40, 7'h40, 7'h40};
      cur_ovf      = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      run_to(10);
      // Assert reset mid-refresh: outputs go inactive before any clock edge.
      reset = 1'b0;
      #1;
      push_inactive();
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      // First cycle after release still inactive, then "0000" scans out.
      push_inactive();
      for (int d = 1; d <= 4; d++) push_busy(d, 1'b0);
      push_scan(1, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
      run_to(16);

      apply(16'hBEEF, 1'b0, {7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0);
      apply(16'hA5C0, 1'b0, {7'h08, 7'h12, 7'h46, 7'h40}, 1'b0);
      apply(16'h1D89, 1'b0, {7'h79, 7'h21, 7'h00, 7'h10}, 1'b0);
      apply(16'd1234, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0);
      apply(16'd65535, 1'b1, {7'h12, 7'h12, 7'h30, 7'h12}, 1'b1);

      // 100, then 42 while the first conversion is running.
      s100 = {7'h40, 7'h79, 7'h40, 7'h40};
      s42  = {7'h40, 7'h40, 7'h19, 7'h24};
      k = cyc;
      bus_if.value = 16'd100;
      for (int d = k + 1; d <= k + 38; d++) push_busy(d, !((d == k + 19) || (d == k + 38)));
      push_digit(k + 19, cur_segs, cur_ovf);
      push_digit(k + 20, s100, 1'b0);
      push_scan(k + 20, s100, 1'b0);
      run_to(k + 3);
      bus_if.value = 16'd42;
      push_digit(k + 38, s100, 1'b0);
      push_digit(k + 39, s42, 1'b0);
      push_scan(k + 39, s42, 1'b0);
      cur_segs = s42;
      cur_ovf  = 1'b0;
      run_to(k + 56);

      apply(16'd7, 1'b1, BZ ? {7'h7F, 7'h7F, 7'h7F, 7'h78} : {7'h40, 7'h40, 7'h40, 7'h78}, 1'b0);
      apply(16'd0, 1'b1, BZ ? {7'h7F, 7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
      apply(16'h00F0, 1'b0, BZ ? {7'h7F, 7'h7F, 7'h0E, 7'h40} : {7'h40, 7'h40, 7'h0E, 7'h40}, 1'b0);
      // Mode-only change of the same word: 0x00F0 = 240 decimal.
      apply(16'h00F0, 1'b1, BZ ? {7'h7F, 7'h24, 7'h19, 7'h40} : {7'h40, 7'h24, 7'h19, 7'h40}, 1'b0);

      finish_req = 1'b1;
      repeat (5) @(posedge clock);
      $display("FAIL monitor: summary not reached");
      $fatal(1, "monitor did not finish");
   end

endmodule
